ryg_lamp_monitor: RTL and testbench



---
 rtl/ryg_lamp_monitor.sv | 232 +++++++++++++++++++++++
 tb/tb_ryg_lamp_monitor.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ryg_lamp_monitor.sv
// ryg_lamp_monitor: checks the RYG FSM requests, drives lamps, flashes yellow on fault.
// Optional macro RYG_FAULT_CLR_EN adds a synchronous fault_clr input.
module ryg_lamp_monitor #(
  parameter int GREEN_LEN  = 6,
  parameter int YELLOW_LEN = 2,
  parameter int FLASH_DIV  = 4
) (
  input  logic       clk,
  input  logic       rst,
`ifdef RYG_FAULT_CLR_EN
  input  logic       fault_clr,
`endif
  input  logic [1:0] r_in,
  input  logic [1:0] y_in,
  input  logic [1:0] g_in,
  output logic [1:0] lamp_r,
  output logic [1:0] lamp_y,
  output logic [1:0] lamp_g,
  output logic [3:0] countdown,
  output logic [1:0] phase,
  output logic       fault,
  output logic [2:0] fault_code
);

  localparam int FC_W = $clog2(FLASH_DIV) + 1;
  localparam logic [3:0] G_LEN = 4'(GREEN_LEN);
  localparam logic [3:0] Y_LEN = 4'(YELLOW_LEN);
  localparam logic [FC_W-1:0] FC_TOP = FC_W'(FLASH_DIV - 1);

  typedef enum logic [1:0] {
    S_INIT,
    S_RUN,
    S_FAULT
  } state_t;

  state_t          state, state_n;
  logic [1:0]      cap_r, cap_y, cap_g;
  logic            cap_vld;
  logic [1:0]      cur, cur_n;
  logic [3:0]      elapsed, el_n;
  logic [3:0]      el_inc, cur_len;
  logic            first, first_n;
  logic            flash, flash_n;
  logic [FC_W-1:0] fcnt, fcnt_n;
  logic [2:0]      code_n;
  logic            legal;
  logic [1:0]      idx;
  logic            err;
  logic [2:0]      err_code;
  logic            clr;
  logic [1:0]      lr_n, ly_n, lg_n, ph_n;
  logic [3:0]      cd_n;
  logic            flt_n;

`ifdef RYG_FAULT_CLR_EN
  assign clr = fault_clr;
`else
  assign clr = 1'b0;
`endif

  function automatic logic [3:0] len_of(input logic [1:0] p);
    return p[0] ? Y_LEN : G_LEN;
  endfunction

  function automatic logic [5:0] pat_of(input logic [1:0] p);
    logic [5:0] v;
    unique case (p)
      2'd0: v = 6'b01_00_10;
      2'd1: v = 6'b01_10_00;
      2'd2: v = 6'b10_00_01;
      2'd3: v = 6'b10_01_00;
    endcase
    return v;
  endfunction

  // cap_vld keeps the cleared capture regs from being judged as all-zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_r   <= '0;
      cap_y   <= '0;
      cap_g   <= '0;
      cap_vld <= 1'b0;
    end else begin
      cap_r   <= r_in;
      cap_y   <= y_in;
      cap_g   <= g_in;
      cap_vld <= 1'b1;
    end
  end

  always_comb begin
    legal = 1'b1;
    idx   = 2'd0;
    case ({cap_r, cap_y, cap_g})
      6'b01_00_10: idx = 2'd0;
      6'b01_10_00: idx = 2'd1;
      6'b10_00_01: idx = 2'd2;
      6'b10_01_00: idx = 2'd3;
      default:     legal = 1'b0;
    endcase
  end

  assign el_inc  = elapsed + 4'd1;
  assign cur_len = len_of(cur);

  always_comb begin
    state_n  = state;
    cur_n    = cur;
    el_n     = elapsed;
    first_n  = first;
    flash_n  = flash;
    fcnt_n   = fcnt;
    code_n   = fault_code;
    err      = 1'b0;
    err_code = 3'd0;
    case (state)
      S_INIT: begin
        if (cap_vld) begin
          if (!legal) begin
            err      = 1'b1;
            err_code = 3'd1;
          end else begin
            state_n = S_RUN;
            cur_n   = idx;
            el_n    = 4'd0;
            first_n = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (!legal) begin
          err      = 1'b1;
          err_code = 3'd1;
        end else if (idx == cur) begin
          if (el_inc == cur_len) begin
            err      = 1'b1;
            err_code = 3'd3;
          end else begin
            el_n = el_inc;
          end
        end else if (idx == 2'(cur + 2'd1)) begin
          if (!first && el_inc != cur_len) begin
            err      = 1'b1;
            err_code = 3'd4;
          end else begin
            cur_n   = idx;
            el_n    = 4'd0;
            first_n = 1'b0;
          end
        end else begin
          err      = 1'b1;
          err_code = 3'd2;
        end
      end
      S_FAULT: begin
        if (clr) begin
          state_n = S_INIT;
          code_n  = 3'd0;
          cur_n   = 2'd0;
          el_n    = 4'd0;
          first_n = 1'b0;
          flash_n = 1'b0;
          fcnt_n  = '0;
        end else if (fcnt == FC_TOP) begin
          fcnt_n  = '0;
          flash_n = ~flash;
        end else begin
          fcnt_n = fcnt + 1'b1;
        end
      end
      default: state_n = S_INIT;
    endcase
    if (err) begin
      state_n = S_FAULT;
      code_n  = err_code;
      flash_n = 1'b1;
      fcnt_n  = '0;
    end
  end

  always_comb begin
    {lr_n, ly_n, lg_n} = 6'b11_00_00;
    cd_n  = 4'd0;
    ph_n  = 2'd0;
    flt_n = 1'b0;
    case (state_n)
      S_RUN: begin
        {lr_n, ly_n, lg_n} = pat_of(cur_n);
        cd_n = len_of(cur_n) - el_n;
        ph_n = cur_n;
      end
      S_FAULT: begin
        {lr_n, ly_n, lg_n} = {2'b00, flash_n, flash_n, 2'b00};
        flt_n = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_INIT;
      cur        <= 2'd0;
      elapsed    <= 4'd0;
      first      <= 1'b0;
      flash      <= 1'b0;
      fcnt       <= '0;
      fault_code <= 3'd0;
      fault      <= 1'b0;
      lamp_r     <= 2'b11;
      lamp_y     <= 2'b00;
      lamp_g     <= 2'b00;
      countdown  <= 4'd0;
      phase      <= 2'd0;
    end else begin
      state      <= state_n;
      cur        <= cur_n;
      elapsed    <= el_n;
      first      <= first_n;
      flash      <= flash_n;
      fcnt       <= fcnt_n;
      fault_code <= code_n;
      fault      <= flt_n;
      lamp_r     <= lr_n;
      lamp_y     <= ly_n;
      lamp_g     <= lg_n;
      countdown  <= cd_n;
      phase      <= ph_n;
    end
  end

endmodule

// File: tb/tb_ryg_lamp_monitor.sv
// tb_ryg_lamp_monitor: scoreboard bench for ryg_lamp_monitor.
// Expected outputs are queued per driven sample and compared two cycles later.
module tb_ryg_lamp_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       fault_clr;
  logic [1:0] r_in, y_in, g_in;
  logic [1:0] lamp_r, lamp_y, lamp_g;
  logic [3:0] countdown;
  logic [1:0] phase;
  logic       fault;
  logic [2:0] fault_code;

  int n_cmp = 0;
  int n_bad = 0;

  logic [5:0]  stim_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] sb[$];

  localparam logic [5:0] PT [4] = '{
    6'b01_00_10, 6'b01_10_00, 6'b10_00_01, 6'b10_01_00
  };
  localparam logic [15:0] E_INIT = {6'b11_00_00, 4'd0, 2'd0, 1'b0, 3'd0};

  wire [15:0] obs = {lamp_r, lamp_y, lamp_g, countdown, phase, fault, fault_code};

  always #5 clk = ~clk;

  ryg_lamp_monitor #(
    .GREEN_LEN (6),
    .YELLOW_LEN(2),
    .FLASH_DIV (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef RYG_FAULT_CLR_EN
    .fault_clr (fault_clr),
`endif
    .r_in      (r_in),
    .y_in      (y_in),
    .g_in      (g_in),
    .lamp_r    (lamp_r),
    .lamp_y    (lamp_y),
    .lamp_g    (lamp_g),
    .countdown (countdown),
    .phase     (phase),
    .fault     (fault),
    .fault_code(fault_code)
  );

  task automatic add_run(input int p, input int n, input int len);
    for (int k = 0; k < n; k++) begin
      stim_q.push_back(PT[p]);
      exp_q.push_back({PT[p], 4'(len - k), 2'(p), 1'b0, 3'd0});
    end
  endtask

  task automatic add_flt(input logic [5:0] s, input logic [2:0] code, input int n);
    logic fl;
    for (int k = 0; k < n; k++) begin
      fl = ((k / 4) % 2) == 0;
      stim_q.push_back(s);
      exp_q.push_back({2'b00, fl, fl, 2'b00, 4'd0, 2'd0, 1'b1, code});
    end
  endtask

  task automatic do_reset;
    rst = 1'b0;
    stim_q.delete();
    exp_q.delete();
    sb.delete();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (obs !== E_INIT) begin
      n_bad++;
      $display("FAIL reset_async: got %h want %h", obs, E_INIT);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (obs !== E_INIT) begin
      n_bad++;
      $display("FAIL reset_hold: got %h want %h", obs, E_INIT);
    end
  endtask

  task automatic test_sequence;
    int n;
    logic [15:0] e;
    do_reset();
    for (int c = 0; c < 2; c++) begin
      add_run(0, 6, 6);
      add_run(1, 2, 2);
      add_run(2, 6, 6);
      add_run(3, 2, 2);
    end
    n = stim_q.size();
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        e = sb.pop_front();
        n_cmp++;
        if (obs !== e) begin
          n_bad++;
          $display("FAIL seq[%0d]: got %h want %h", i - 2, obs, e);
        end
      end
      if (i < n) begin
        {r_in, y_in, g_in} = stim_q[i];
        sb.push_back(exp_q[i]);
      end
    end
  endtask

  task automatic test_conflict;
    int n;
    logic [15:0] e;
    do_reset();
    add_run(0, 6, 6);
    add_run(1, 2, 2);
    add_flt(6'b00_00_11, 3'd1, 10);
    n = stim_q.size();
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        e = sb.pop_front();
        n_cmp++;
        if (obs !== e) begin
          n_bad++;
          $display("FAIL conflict[%0d]: got %h want %h", i - 2, obs, e);
        end
      end
      if (i < n) begin
        {r_in, y_in, g_in} = stim_q[i];
        sb.push_back(exp_q[i]);
      end
    end
  endtask

  task automatic test_too_long;
    int n;
    logic [15:0] e;
    do_reset();
    add_run(0, 6, 6);
    add_run(1, 2, 2);
    add_run(2, 6, 6);
    add_run(3, 2, 2);
    add_run(0, 6, 6);
    add_flt(PT[0], 3'd3, 6);
    n = stim_q.size();
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        e = sb.pop_front();
        n_cmp++;
        if (obs !== e) begin
          n_bad++;
          $display("FAIL too_long[%0d]: got %h want %h", i - 2, obs, e);
        end
      end
      if (i < n) begin
        {r_in, y_in, g_in} = stim_q[i];
        sb.push_back(exp_q[i]);
      end
    end
  endtask

  task automatic test_out_of_order;
    int n;
    logic [15:0] e;
    do_reset();
    add_run(0, 6, 6);
    add_flt(PT[2], 3'd2, 3);
    n = stim_q.size();
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        e = sb.pop_front();
        n_cmp++;
        if (obs !== e) begin
          n_bad++;
          $display("FAIL order[%0d]: got %h want %h", i - 2, obs, e);
        end
      end
      if (i < n) begin
        {r_in, y_in, g_in} = stim_q[i];
        sb.push_back(exp_q[i]);
      end
    end
  endtask

  task automatic test_too_short;
    int n;
    logic [15:0] e;
    do_reset();
    add_run(0, 6, 6);
    add_run(1, 2, 2);
    add_run(2, 4, 6);
    add_flt(PT[3], 3'd4, 3);
    n = stim_q.size();
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        e = sb.pop_front();
        n_cmp++;
        if (obs !== e) begin
          n_bad++;
          $display("FAIL too_short[%0d]: got %h want %h", i - 2, obs, e);
        end
      end
      if (i < n) begin
        {r_in, y_in, g_in} = stim_q[i];
        sb.push_back(exp_q[i]);
      end
    end
  endtask

  task automatic test_first_phase;
    int n;
    logic [15:0] e;
    do_reset();
    add_run(2, 3, 6);
    add_run(3, 2, 2);
    add_run(0, 6, 6);
    add_run(1, 2, 2);
    n = stim_q.size();
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        e = sb.pop_front();
        n_cmp++;
        if (obs !== e) begin
          n_bad++;
          $display("FAIL first[%0d]: got %h want %h", i - 2, obs, e);
        end
      end
      if (i < n) begin
        {r_in, y_in, g_in} = stim_q[i];
        sb.push_back(exp_q[i]);
      end
    end
  endtask

  task automatic test_init_illegal;
    int n;
    logic [15:0] e;
    do_reset();
    add_flt(6'b00_00_00, 3'd1, 5);
    n = stim_q.size();
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        e = sb.pop_front();
        n_cmp++;
        if (obs !== e) begin
          n_bad++;
          $display("FAIL init_ill[%0d]: got %h want %h", i - 2, obs, e);
        end
      end
      if (i < n) begin
        {r_in, y_in, g_in} = stim_q[i];
        sb.push_back(exp_q[i]);
      end
    end
  endtask

  task automatic test_priority;
    int n;
    logic [15:0] e;
    do_reset();
    add_run(0, 6, 6);
    add_run(1, 1, 2);
    add_flt(6'b10_00_11, 3'd1, 3);
    n = stim_q.size();
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        e = sb.pop_front();
        n_cmp++;
        if (obs !== e) begin
          n_bad++;
          $display("FAIL prio[%0d]: got %h want %h", i - 2, obs, e);
        end
      end
      if (i < n) begin
        {r_in, y_in, g_in} = stim_q[i];
        sb.push_back(exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_fault;
    int n;
    logic [15:0] e;
    do_reset();
    add_run(0, 1, 6);
    add_flt(PT[2], 3'd2, 6);
    n = stim_q.size();
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        e = sb.pop_front();
        n_cmp++;
        if (obs !== e) begin
          n_bad++;
          $display("FAIL rmf[%0d]: got %h want %h", i - 2, obs, e);
        end
      end
      if (i < n) begin
        {r_in, y_in, g_in} = stim_q[i];
        sb.push_back(exp_q[i]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (obs !== E_INIT) begin
      n_bad++;
      $display("FAIL rmf_async: got %h want %h", obs, E_INIT);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    stim_q.delete();
    exp_q.delete();
    sb.delete();
    add_run(1, 2, 2);
    add_run(2, 6, 6);
    add_run(3, 2, 2);
    n = stim_q.size();
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        e = sb.pop_front();
        n_cmp++;
        if (obs !== e) begin
          n_bad++;
          $display("FAIL rmf_resume[%0d]: got %h want %h", i - 2, obs, e);
        end
      end
      if (i < n) begin
        {r_in, y_in, g_in} = stim_q[i];
        sb.push_back(exp_q[i]);
      end
    end
  endtask

`ifdef RYG_FAULT_CLR_EN
  task automatic test_fault_clr;
    int n;
    logic [15:0] e;
    do_reset();
    add_run(0, 6, 6);
    add_run(1, 2, 2);
    add_run(2, 6, 6);
    add_run(3, 2, 2);
    add_run(0, 6, 6);
    add_flt(PT[0], 3'd3, 3);
    n = stim_q.size();
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        e = sb.pop_front();
        n_cmp++;
        if (obs !== e) begin
          n_bad++;
          $display("FAIL clr[%0d]: got %h want %h", i - 2, obs, e);
        end
      end
      if (i < n) begin
        {r_in, y_in, g_in} = stim_q[i];
        sb.push_back(exp_q[i]);
      end
    end
    @(negedge clk);
    fault_clr = 1'b1;
    {r_in, y_in, g_in} = PT[2];
    @(negedge clk);
    fault_clr = 1'b0;
    n_cmp++;
    if (obs !== E_INIT) begin
      n_bad++;
      $display("FAIL clr_init: got %h want %h", obs, E_INIT);
    end
    @(negedge clk);
    e = {PT[2], 4'd6, 2'd2, 1'b0, 3'd0};
    n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL clr_rerun: got %h want %h", obs, e);
    end
  endtask
`endif

  initial begin
    rst = 1'b0;
    fault_clr = 1'b0;
    {r_in, y_in, g_in} = 6'b0;
    test_reset();
    test_sequence();
    test_conflict();
    test_too_long();
    test_out_of_order();
    test_too_short();
    test_first_phase();
    test_init_illegal();
    test_priority();
    test_reset_mid_fault();
`ifdef RYG_FAULT_CLR_EN
    test_fault_clr();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
